// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and constants for the sequential chunked adder.
// Holds the FSM encoding, default sizes and an index-width helper.
package seq_chunk_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_ripple.sv
// Combinational CHUNK-bit ripple of 1-bit full-adder cells.
// One instance is reused every cycle by the sequential adder.
module chunk_ripple #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock.
// Results land in a shadow register only on the final slice.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             last;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             cco;
    logic             ovf_nx;

    assign last = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    assign ca = op_a[idx*CHUNK +: CHUNK];
    assign cb = op_b[idx*CHUNK +: CHUNK];

    chunk_ripple #(
        .CHUNK(CHUNK)
    ) u_ripple (
        .a (ca),
        .b (cb),
        .ci(carry),
        .s (cs),
        .co(cco)
    );

    // Partial slices accumulate here; sum only sees the finished word.
    always_comb begin
        work_nx = work;
        work_nx[idx*CHUNK +: CHUNK] = cs;
    end

    assign ovf_nx = (op_a[WIDTH-1] == op_b[WIDTH-1])
                  & (work_nx[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    work  <= work_nx;
                    carry <= cco;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        idx  <= '0;
                        sum  <= work_nx;
                        cout <= cco;
                        ovf  <= ovf_nx;
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
